// File: rtl/note_draw_controller.sv
// note_draw_controller: rasterises the note lane into filled squares, one pixel per cycle.
module note_draw_controller #(
  parameter int NUM_NOTES = 10,
  parameter int SQUARE_SIZE = 5,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0,
  parameter logic [2:0] NOTE_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic [NUM_NOTES-1:0] notes,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);
  localparam int SW = NUM_NOTES > 1 ? $clog2(NUM_NOTES) : 1;
  localparam int PW = SQUARE_SIZE > 1 ? $clog2(SQUARE_SIZE) : 1;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_d;
  logic [SW-1:0] slot, slot_d;
  logic [PW-1:0] px, px_d, py, py_d;
  logic [NUM_NOTES-1:0] notes_q, notes_d;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic plot_d, busy_d, done_d, px_end, py_end, last;
  // Counters name the pixel currently on the outputs; a non-stalled edge retires it.
  always_comb begin
    px_end = px == PW'(SQUARE_SIZE - 1);
    py_end = py == PW'(SQUARE_SIZE - 1);
    last = px_end && py_end && slot == SW'(NUM_NOTES - 1);
    state_d = state;
    slot_d = slot;
    px_d = px;
    py_d = py;
    notes_d = notes_q;
    plot_d = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = DRAW;
        notes_d = notes;
        slot_d = '0;
        px_d = '0;
        py_d = '0;
        plot_d = 1'b1;
      end
      DRAW: if (!stall) begin
        if (last) state_d = DONE;
        else begin
          px_d = px_end ? '0 : px + 1'b1;
          py_d = px_end ? (py_end ? '0 : py + 1'b1) : py;
          slot_d = px_end && py_end ? slot + 1'b1 : slot;
          plot_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == DRAW;
    done_d = state_d == DONE;
    x_d = plot_d ? 8'(X_ORIGIN + int'(slot_d) * SQUARE_SIZE + int'(px_d)) : x;
    y_d = plot_d ? 7'(Y_ORIGIN + int'(py_d)) : y;
    colour_d = plot_d ? (notes_d[slot_d] ? NOTE_COLOUR : BG_COLOUR) : colour;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      px <= '0;
      py <= '0;
      notes_q <= '0;
      x <= '0;
      y <= '0;
      colour <= BG_COLOUR;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      slot <= slot_d;
      px <= px_d;
      py <= py_d;
      notes_q <= notes_d;
      x <= x_d;
      y <= y_d;
      colour <= colour_d;
      plot <= plot_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
endmodule

// File: tb/tb_note_draw_controller.sv
// tb_note_draw_controller: vector table plus randomized redraws checked against a pixel-list model.
module tb_note_draw_controller;
  logic clock = 0, reset = 0, start = 0, stall = 0;
  logic [9:0] notes = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy, done;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  typedef struct {logic [9:0] n; int mode; int reds;} vec_t;
  note_draw_controller dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall), .notes(notes),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // mode: 0 plain, 1 random stall, 2 stall 3 at (12,2), 3 notes change, 4 extra starts, 5 reset at 60th plot
  task automatic draw(input logic [9:0] n, input int mode, output int plots, output int reds,
                      output int dcyc, output int stalls, output int lx, output int ly);
    pix_t q[$];
    pix_t e;
    int hold = 0;
    plots = 0; reds = 0; dcyc = -1; stalls = 0; lx = -1; ly = -1;
    for (int s = 0; s < 10; s++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          e.x = 8'(s * 5 + c);
          e.y = 7'(r);
          e.c = n[s] ? 3'b100 : 3'b000;
          q.push_back(e);
        end
    notes = n; stall = 0; start = 1;
    @(negedge clock);
    start = 0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (cyc == 1) chk("busy_rise", int'(busy), 1);
      if (done) begin
        dcyc = cyc;
        chk("busy_at_done", int'(busy), 0);
        chk("plot_at_done", int'(plot), 0);
        stall = 0;
        if (mode == 4) start = 1;
        @(negedge clock);
        start = 0;
        chk("done_single", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
        return;
      end
      if (plot) begin
        plots++;
        if (q.size() == 0) chk("extra_plot", plots, 250);
        else begin
          e = q.pop_front();
          checks++;
          if ({x, y, colour} !== {e.x, e.y, e.c}) begin
            errors++;
            $display("FAIL pixel %0d: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b",
                     plots, x, y, colour, e.x, e.y, e.c);
          end
        end
        if (colour == 3'b100) reds++;
        lx = int'(x);
        ly = int'(y);
      end else if (busy) begin
        chk("stall_hold_x", int'(x), lx);
        chk("stall_hold_y", int'(y), ly);
      end
      if (mode == 3 && cyc == 1) notes = '1;
      if (mode == 4) start = plot && plots == 100;
      if (mode == 2 && plot && x == 12 && y == 2) hold = 3;
      stall = mode == 1 ? ($urandom_range(0, 3) == 0) : hold > 0;
      if (hold > 0) hold--;
      if (busy && stall) stalls++;
      if (mode == 5 && plot && plots == 60) begin
        reset = 1; stall = 0;
        @(negedge clock);
        reset = 0;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_x", int'(x), 0);
        chk("abort_y", int'(y), 0);
        chk("abort_done", int'(done), 0);
        repeat (4) begin
          @(negedge clock);
          chk("abort_no_done", int'(done), 0);
        end
        return;
      end
      @(negedge clock);
    end
    chk("timeout", 0, 1);
  endtask
  initial begin
    vec_t v[8];
    int p, r, d, s, lx, ly;
    logic [9:0] rn;
    v[0] = '{10'b0000000001, 0, 25};
    v[1] = '{10'b1010101010, 0, 125};
    v[2] = '{10'b1000000000, 0, 25};
    v[3] = '{10'b1111111111, 0, 250};
    v[4] = '{10'b0000000000, 2, 0};
    v[5] = '{10'b0000000001, 3, 25};
    v[6] = '{10'b0110000011, 4, 100};
    v[7] = '{10'b1100110011, 1, 150};
    reset = 1;
    @(negedge clock);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      draw(v[i].n, v[i].mode, p, r, d, s, lx, ly);
      chk($sformatf("plots[%0d]", i), p, 250);
      chk($sformatf("reds[%0d]", i), r, v[i].reds);
      chk($sformatf("done_cycle[%0d]", i), d, 251 + s);
      chk($sformatf("last_x[%0d]", i), lx, 49);
      chk($sformatf("last_y[%0d]", i), ly, 4);
      if (v[i].mode == 2) chk("stall_count", s, 3);
    end
    start = 1; reset = 1;
    @(negedge clock);
    chk("rst_wins_busy", int'(busy), 0);
    chk("rst_wins_plot", int'(plot), 0);
    start = 0; reset = 0;
    @(negedge clock);
    chk("rst_wins_idle", int'(busy), 0);
    draw(10'b0101010101, 5, p, r, d, s, lx, ly);
    draw(10'b0101010101, 0, p, r, d, s, lx, ly);
    chk("redraw_plots", p, 250);
    chk("redraw_reds", r, 125);
    chk("redraw_done", d, 251);
    repeat (4) begin
      rn = 10'($urandom);
      draw(rn, 1, p, r, d, s, lx, ly);
      chk("rand_plots", p, 250);
      chk("rand_reds", r, 25 * $countones(rn));
      chk("rand_done", d, 251 + s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_draw_controller.md
# note_draw_controller

Sequences the on-screen note lane for the VGA path. On a `start` pulse it latches a snapshot of the lowest shifter note bits and walks every note slot, emitting one pixel per cycle (x, y, colour, plot) so that each slot is drawn as a filled square: note colour if the slot's bit is set, background colour otherwise. It sits between the note shifter and the VGA adapter, and is started once per frame tick by the game top level.

## Interface
- `NUM_NOTES`, 10, number of note slots drawn, slot i taken from `notes[i]`
- `SQUARE_SIZE`, 5, square side in pixels and horizontal pitch between slot origins
- `X_ORIGIN`, 0, x-coordinate of slot 0's left column
- `Y_ORIGIN`, 0, y-coordinate of every square's top row
- `NOTE_COLOUR`, 3'b100, colour for a set note bit (red)
- `BG_COLOUR`, 3'b000, colour for a clear note bit (black)

- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a full lane redraw; sampled only in IDLE
- `stall`  in  1  VGA side not ready; freezes drawing while high
- `notes`  in  NUM_NOTES  lowest note bits from the shifter
- `x`  out  8  pixel x-coordinate
- `y`  out  7  pixel y-coordinate
- `colour`  out  3  pixel colour
- `plot`  out  1  write-enable for the current x/y/colour
- `busy`  out  1  redraw in progress
- `done`  out  1  single-cycle pulse after the last pixel

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: `plot`=0, `busy`=0. If `start`=1, latch `notes` into `notes_q`, clear `slot`, `px` and `py`, and go to DRAW.
- DRAW, `stall`=0:
  - Present `plot`=1, `x`=X_ORIGIN+slot*SQUARE_SIZE+px, `y`=Y_ORIGIN+py.
  - `colour`=NOTE_COLOUR if `notes_q[slot]` is set, else BG_COLOUR.
  - Then advance in raster order: `px` first; on `px`=SQUARE_SIZE-1 wrap `px` to 0 and increment `py`; on `py`=SQUARE_SIZE-1 also wrap `py` to 0 and increment `slot`.
  - After pixel (SQUARE_SIZE-1, SQUARE_SIZE-1) of slot NUM_NOTES-1, go to DONE.
- DRAW, `stall`=1:
  - `plot`=0.
  - `slot`, `px`, `py`, `x`, `y` and `colour` hold.
  - No pixel is skipped or repeated.
- DONE: `done`=1 and `plot`=0 for exactly one cycle, then IDLE.
- `start` in DRAW or DONE is ignored; it does not queue and does not restart the redraw.
- `notes` changes after the latch have no effect until the next accepted `start`.
- Arithmetic is unsigned. The counters `slot`, `px` and `py` are sized from the parameters. The coordinate sums must fit 8 and 7 bits:
  - X_ORIGIN+NUM_NOTES*SQUARE_SIZE-1 ≤ 255
  - Y_ORIGIN+SQUARE_SIZE-1 ≤ 127
  - Defaults give max x=49 and max y=4.

## Timing
- Reset values: `x`=0, `y`=0, `colour`=BG_COLOUR, `plot`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset is synchronous. Asserting `reset` mid-DRAW aborts the redraw at the next edge with reset values; no `done` pulse is produced.
- All outputs are registered. If `start` is sampled at edge k, `busy` and the first `plot` go high after edge k with pixel (X_ORIGIN, Y_ORIGIN).
- With no stall, `plot` is high for exactly NUM_NOTES*SQUARE_SIZE² consecutive cycles (250 with defaults). `done` is high in the next cycle; `busy` is low in that same cycle.
- Each stalled cycle extends the redraw by one cycle.
- The earliest next `start` is accepted on the cycle after `done`. Minimum start-to-start period is 252 cycles at defaults.
- `stall` acts on the same edge it is sampled. `stall` in IDLE or DONE has no effect.
- `start` and `reset` high together: reset wins.

## Test plan
- Reset, then `notes`=10'b0000000001 and a one-cycle `start` -> `busy` rises next cycle. First 25 plots are x=0..4, y=0..4 with colour 3'b100. The remaining 225 plots have colour 3'b000. The last plot is x=49, y=4. `done` pulses once at cycle 251 after `start`.
- `notes`=10'b1010101010 -> slots 1, 3, 5, 7 and 9 (x 5-9, 15-19, 25-29, 35-39, 45-49) are 3'b100; all other slots are 3'b000. Exactly 250 plots.
- Change `notes` to all ones one cycle after `start` -> drawn colours still match the latched value.
- Hold `stall` high for 3 cycles at pixel x=12, y=2 -> `plot`=0 and x/y hold for 3 cycles. Drawing resumes at x=13, y=2. `done` is delayed by exactly 3 cycles.
- Pulse `start` again at the 100th plot -> no restart; plot count stays 250 and a single `done`.
- Assert `reset` at the 60th plot -> next cycle `plot`=0, `busy`=0, x=y=0, and no `done`. A following `start` redraws all 250 pixels from x=0.
